uart_program_loader: RTL and testbench

- Hardware bootstrap loader: receives a program image as a byte stream from the host-side Uart receive buffer and writes it word-by-word into instruction Memory.
- On completion it raises load_completed, which releases core/main_mem/uart reset.
- Image format: 4-byte little-endian word count N, then N instruction words, each little-endian.

---
 rtl/uart_program_loader.sv | 108 ++++++++++
 tb/tb_uart_program_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Boot loader: pulls a length-prefixed little-endian image from the Uart receive buffer into instruction memory.
// Releases the rest of the system through load_completed. A header word larger than MAX_WORDS latches load_error instead.
module uart_program_loader #(
   parameter int          BUF_LEN_WIDTH = 16,
   parameter int          MAX_WORDS     = 16384,
   parameter logic [31:0] BASE_ADDR     = 32'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [BUF_LEN_WIDTH-1:0] rx_buf_len,
   output logic                     rx_req,
   input  logic                     rx_ack,
   input  logic [7:0]               rx_data,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_data,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic                     load_completed,
   output logic                     load_error,
   output logic [31:0]              words_loaded
);

   localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

   typedef enum logic [2:0] {S_HDR, S_DATA, S_WRITE, S_DONE, S_ERROR} state_t;

   state_t      state, state_nxt;
   logic [1:0]  byte_idx;
   logic [23:0] low_bytes;
   logic [31:0] n_words;
   logic [31:0] full_word;
   logic        byte_take;
   logic        word_done;
   logic        fetch_state;

   assign byte_take   = rx_req & rx_ack;
   assign word_done   = byte_take && (byte_idx == 2'd3);
   assign full_word   = {rx_data, low_bytes};
   assign fetch_state = (state == S_HDR) || (state == S_DATA);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_HDR;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_HDR: begin
            if (word_done) begin
               if (full_word == 32'd0)     state_nxt = S_DONE;
               else if (full_word > MAX_W) state_nxt = S_ERROR;
               else                        state_nxt = S_DATA;
            end
         end
         S_DATA:  if (word_done) state_nxt = S_WRITE;
         S_WRITE: begin
            if (mem_ready)
               state_nxt = (words_loaded + 32'd1 == n_words) ? S_DONE : S_DATA;
         end
         default: state_nxt = state;
      endcase
   end

   always_comb begin
      mem_valid      = (state == S_WRITE);
      load_completed = (state == S_DONE);
      load_error     = (state == S_ERROR);
   end

   // rx_req is only raised from a low state, so the cycle after a capture is always idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_req       <= 1'b0;
         byte_idx     <= 2'd0;
         low_bytes    <= 24'd0;
         n_words      <= 32'd0;
         mem_data     <= 32'd0;
         mem_addr     <= BASE_ADDR;
         words_loaded <= 32'd0;
      end else begin
         if (rx_req) begin
            if (rx_ack) rx_req <= 1'b0;
         end else if (fetch_state && (rx_buf_len != '0)) begin
            rx_req <= 1'b1;
         end

         if (byte_take) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0:    low_bytes[7:0]   <= rx_data;
               2'd1:    low_bytes[15:8]  <= rx_data;
               2'd2:    low_bytes[23:16] <= rx_data;
               default: low_bytes        <= low_bytes;
            endcase
         end

         if (word_done && (state == S_HDR))  n_words  <= full_word;
         if (word_done && (state == S_DATA)) mem_data <= full_word;

         if ((state == S_WRITE) && mem_ready) begin
            words_loaded <= words_loaded + 32'd1;
            mem_addr     <= mem_addr + 32'd4;
         end
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: byte-queue Uart model and memory model driven on the falling edge.
module tb_uart_program_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] rx_buf_len = 16'd0;
   logic        rx_req;
   logic        rx_ack = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic [31:0] mem_addr, mem_data, words_loaded;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic        load_completed, load_error;

   uart_program_loader dut (
      .clk(clk), .reset(reset), .rx_buf_len(rx_buf_len), .rx_req(rx_req), .rx_ack(rx_ack),
      .rx_data(rx_data), .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
      .mem_ready(mem_ready), .load_completed(load_completed), .load_error(load_error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   logic [7:0]  byte_q[$];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int n_vec = 0, n_err = 0;
   int cyc = 0, done_cyc = -1, last_ack_cyc = -1;
   int valid_cyc = 0, valid_run = 0, ready_lat = 0;
   int unstable = 0, req_in_write = 0, req_empty = 0, b2b = 0;
   logic [31:0] last_addr = 32'd0, last_data = 32'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Uart and memory models; everything the DUT samples changes on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         if (rx_req && rx_ack) b2b++;
         if (rx_req && byte_q.size() == 0 && !rx_ack) req_empty++;
         if (rx_req && mem_valid) req_in_write++;
         if (mem_valid) begin
            valid_cyc++;
            if (valid_run > 0 && (mem_addr !== last_addr || mem_data !== last_data)) unstable++;
            valid_run++;
            last_addr = mem_addr;
            last_data = mem_data;
         end else begin
            valid_run = 0;
         end
         mem_ready = mem_valid && (valid_run > ready_lat);
         if (mem_ready) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
         end
         if (load_completed && done_cyc < 0) done_cyc = cyc;
         if (rx_req && !rx_ack && byte_q.size() > 0) begin
            rx_data = byte_q.pop_front();
            rx_ack = 1'b1;
            last_ack_cyc = cyc;
         end else begin
            rx_ack = 1'b0;
         end
         rx_buf_len = 16'(byte_q.size());
      end else begin
         rx_ack = 1'b0;
         mem_ready = 1'b0;
         valid_run = 0;
         rx_buf_len = 16'd0;
      end
   end

   task automatic clear_models(input int lat);
      byte_q.delete();
      wr_addr.delete();
      wr_data.delete();
      done_cyc = -1;
      last_ack_cyc = -1;
      valid_cyc = 0;
      unstable = 0;
      req_in_write = 0;
      req_empty = 0;
      ready_lat = lat;
   endtask

   task automatic restart(input int lat);
      @(negedge clk);
      #2 reset = 1'b0;
      clear_models(lat);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) byte_q.push_back(w[8*i +: 8]);
   endtask

   task automatic wait_end(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (load_completed || load_error) break;
      end
      if (!(load_completed || load_error)) check({tag, "_timeout"}, {31'd0, load_completed | load_error}, 32'd1);
      repeat (6) @(negedge clk);
   endtask

   initial begin
      // Reset values while reset is held low.
      repeat (2) @(negedge clk);
      check("rst_rx_req", {31'd0, rx_req}, 32'd0);
      check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_words", words_loaded, 32'd0);
      check("rst_done", {31'd0, load_completed}, 32'd0);
      check("rst_err", {31'd0, load_error}, 32'd0);
      #2 reset = 1'b1;

      // Two-word image, immediate ready; trailing byte must stay in the buffer.
      restart(0);
      push_word(32'd2); push_word(32'h13); push_word(32'h6F); byte_q.push_back(8'h55);
      wait_end("t1", 400);
      check("t1_done", {31'd0, load_completed}, 32'd1);
      check("t1_nwr", wr_addr.size(), 32'd2);
      check("t1_addr0", wr_addr.size() > 0 ? wr_addr[0] : 32'hFFFFFFFF, 32'd0);
      check("t1_data0", wr_data.size() > 0 ? wr_data[0] : 32'hFFFFFFFF, 32'h13);
      check("t1_addr1", wr_addr.size() > 1 ? wr_addr[1] : 32'hFFFFFFFF, 32'd4);
      check("t1_data1", wr_data.size() > 1 ? wr_data[1] : 32'hFFFFFFFF, 32'h6F);
      check("t1_words", words_loaded, 32'd2);
      check("t1_mem_addr", mem_addr, 32'd8);
      check("t1_left", byte_q.size(), 32'd1);
      check("t1_rx_req", {31'd0, rx_req}, 32'd0);

      // Empty image.
      restart(0);
      push_word(32'd0);
      wait_end("t2", 200);
      check("t2_done", {31'd0, load_completed}, 32'd1);
      check("t2_latency", {31'd0, (done_cyc - last_ack_cyc) <= 2 && done_cyc > 0}, 32'd1);
      check("t2_valid", valid_cyc, 32'd0);
      check("t2_words", words_loaded, 32'd0);

      // Oversized header, followed by bytes that must not be fetched.
      restart(0);
      byte_q.push_back(8'h01); byte_q.push_back(8'h40); byte_q.push_back(8'h00); byte_q.push_back(8'h00);
      push_word(32'hCAFEF00D);
      wait_end("t3", 200);
      repeat (20) @(negedge clk);
      check("t3_err", {31'd0, load_error}, 32'd1);
      check("t3_done", {31'd0, load_completed}, 32'd0);
      check("t3_valid", valid_cyc, 32'd0);
      check("t3_left", byte_q.size(), 32'd4);
      check("t3_rx_req", {31'd0, rx_req}, 32'd0);

      // Memory stalls for five cycles.
      restart(5);
      push_word(32'd1); push_word(32'h11223344);
      wait_end("t4", 300);
      check("t4_done", {31'd0, load_completed}, 32'd1);
      check("t4_valid_cyc", valid_cyc, 32'd6);
      check("t4_stable", unstable, 32'd0);
      check("t4_req_in_wr", req_in_write, 32'd0);
      check("t4_nwr", wr_data.size(), 32'd1);
      check("t4_data", wr_data.size() > 0 ? wr_data[0] : 32'hFFFFFFFF, 32'h11223344);

      // Buffer runs dry mid-word for 20 cycles.
      restart(0);
      push_word(32'd1); byte_q.push_back(8'hAA); byte_q.push_back(8'hBB);
      for (int i = 0; i < 300 && byte_q.size() != 0; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      check("t5_gap_req", {31'd0, rx_req}, 32'd0);
      byte_q.push_back(8'hCC); byte_q.push_back(8'hDD);
      wait_end("t5", 300);
      check("t5_done", {31'd0, load_completed}, 32'd1);
      check("t5_req_empty", req_empty, 32'd0);
      check("t5_data", wr_data.size() > 0 ? wr_data[0] : 32'hFFFFFFFF, 32'hDDCCBBAA);
      check("t5_addr", wr_addr.size() > 0 ? wr_addr[0] : 32'hFFFFFFFF, 32'd0);

      // Reset after two data bytes, then a fresh one-word image.
      restart(0);
      push_word(32'd1); byte_q.push_back(8'h11); byte_q.push_back(8'h22);
      for (int i = 0; i < 300 && byte_q.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_words", words_loaded, 32'd0);
      check("t6_rst_req", {31'd0, rx_req}, 32'd0);
      clear_models(0);
      @(negedge clk);
      #2 reset = 1'b1;
      push_word(32'd1); push_word(32'hDEADBEEF);
      wait_end("t6", 300);
      check("t6_done", {31'd0, load_completed}, 32'd1);
      check("t6_nwr", wr_data.size(), 32'd1);
      check("t6_data", wr_data.size() > 0 ? wr_data[0] : 32'hFFFFFFFF, 32'hDEADBEEF);
      check("t6_addr", wr_addr.size() > 0 ? wr_addr[0] : 32'hFFFFFFFF, 32'd0);
      check("b2b_requests", b2b, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
